// File: rtl/dnn_result_postproc_if.sv
// Activation stream toward the next layer: valid/ready handshake carrying a
// requantised activation and its position within the batch.
interface dnn_result_postproc_if #(
    parameter int LOGDEPTH = 6,
    parameter int OUT_W    = 16
);
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic [LOGDEPTH-1:0] out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/dnn_result_postproc.sv
// Result post-processor: fetches one 64-word batch from the dot-product
// accelerator, applies bias, optional ReLU and Q16.16 -> Q8.8 requantisation
// with saturation, and streams the activations out through a fall-through FIFO.
module dnn_result_postproc #(
    parameter int DEPTH    = 64,
    parameter int LOGDEPTH = 6,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           bias,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    output logic [LOGDEPTH:0]     sat_count,
    output logic                  EN_readMem,
    input  logic                  VALID_memVal,
    input  logic [31:0]           memVal_data,
    dnn_result_postproc_if.master outStream
);

    localparam logic [LOGDEPTH:0]   LAST_BEAT = (LOGDEPTH + 1)'(DEPTH - 1);
    localparam logic [LOGDEPTH:0]   FIFO_FULL = (LOGDEPTH + 1)'(DEPTH);
    localparam logic signed [32:0]  OUT_MAX   = 33'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [32:0]  OUT_MIN   = -OUT_MAX - 33'sd1;

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, FLUSH} state_t;

    state_t                     state;
    logic [LOGDEPTH:0]          beatCnt;
    logic [31:0]                biasReg;
    logic                       reluEn;

    logic                       s1Valid;
    logic [LOGDEPTH-1:0]        s1Idx;
    logic signed [32:0]         s1Sum;
    logic                       s2Valid;
    logic [LOGDEPTH-1:0]        s2Idx;
    logic [OUT_W-1:0]           s2Data;

    logic signed [32:0]         reluSum;
    logic signed [32:0]         shSum;
    logic [OUT_W-1:0]           satData;
    logic                       satHit;

    logic [LOGDEPTH+OUT_W-1:0]  fifoMem [DEPTH];
    logic [LOGDEPTH-1:0]        wrPtr;
    logic [LOGDEPTH-1:0]        rdPtr;
    logic [LOGDEPTH:0]          fifoCount;
    logic [LOGDEPTH+OUT_W-1:0]  head;
    logic                       fifoEmpty;
    logic                       fifoFull;
    logic                       push;
    logic                       pop;

    logic                       startAccept;
    logic                       beatAccept;

    assign fifoEmpty   = (fifoCount == '0);
    assign fifoFull    = (fifoCount == FIFO_FULL);
    assign startAccept = (state == IDLE) && start && fifoEmpty;
    assign beatAccept  = (state == COLLECT) && VALID_memVal;
    assign push        = s2Valid;
    assign pop         = !fifoEmpty && outStream.out_ready;

    // Batch control FSM with registered busy/done/read-request outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // in this block samples pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            EN_readMem <= 1'b0;
            beatCnt    <= '0;
            biasReg    <= '0;
            reluEn     <= 1'b0;
        end else begin
            done       <= 1'b0;
            EN_readMem <= 1'b0;
            case (state)
                IDLE: begin
                    if (startAccept) begin
                        biasReg    <= bias;
                        reluEn     <= relu_en;
                        beatCnt    <= '0;
                        busy       <= 1'b1;
                        EN_readMem <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: state <= COLLECT;
                COLLECT: begin
                    if (VALID_memVal) begin
                        beatCnt <= beatCnt + 1'b1;
                        if (beatCnt == LAST_BEAT) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Stage 2 drains unconditionally, so once stage 1 is empty the
                    // last result lands in the FIFO on this same edge.
                    if (!s1Valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: widen to 33 bits and add the latched bias without wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Idx   <= '0;
            s1Sum   <= '0;
        end else begin
            s1Valid <= beatAccept;
            s1Idx   <= beatCnt[LOGDEPTH-1:0];
            s1Sum   <= $signed({memVal_data[31], memVal_data}) + $signed({biasReg[31], biasReg});
        end
    end

    // Stage 2 combinational part: ReLU, arithmetic shift, saturation to OUT_W.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path infers a latch.
        reluSum = s1Sum;
        satHit  = 1'b0;
        if (reluEn && (s1Sum < 0)) reluSum = '0;
        shSum   = reluSum >>> SHIFT;
        satData = shSum[OUT_W-1:0];
        if (shSum > OUT_MAX) begin
            satData = OUT_MAX[OUT_W-1:0];
            satHit  = 1'b1;
        end else if (shSum < OUT_MIN) begin
            satData = OUT_MIN[OUT_W-1:0];
            satHit  = 1'b1;
        end
    end

    // Stage 2 register and per-batch saturation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid   <= 1'b0;
            s2Idx     <= '0;
            s2Data    <= '0;
            sat_count <= '0;
        end else begin
            s2Valid <= s1Valid;
            s2Idx   <= s1Idx;
            s2Data  <= satData;
            if (startAccept)           sat_count <= '0;
            else if (s1Valid && satHit) sat_count <= sat_count + 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; occupancy lives in the pointers,
        // so stale entries are never presented.
        if (push) fifoMem[wrPtr] <= {s2Idx, s2Data};
    end

    // Start waits for an empty FIFO, so a push into a full FIFO is a design error.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifoFull));
    end

    // First-word fall-through head; zero while empty.
    assign head                = fifoMem[rdPtr];
    assign outStream.out_valid = !fifoEmpty;
    assign outStream.out_data  = fifoEmpty ? '0 : head[OUT_W-1:0];
    assign outStream.out_idx   = fifoEmpty ? '0 : head[OUT_W +: LOGDEPTH];

endmodule
